// File: rtl/stream_demux_if.sv
// Handshake bundle for stream_demux: one input stream, two routed output streams.
interface stream_demux_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] o0_data;
  logic             o0_last;
  logic             o0_valid;
  logic             o0_ready;

  logic [WIDTH-1:0] o1_data;
  logic             o1_last;
  logic             o1_valid;
  logic             o1_ready;

  // Source of the input stream and sink of both outputs.
  modport master (
    output in_data, in_sel, in_last, in_valid,
    input  in_ready,
    input  o0_data, o0_last, o0_valid,
    output o0_ready,
    input  o1_data, o1_last, o1_valid,
    output o1_ready
  );

  modport slave (
    input  in_data, in_sel, in_last, in_valid,
    output in_ready,
    output o0_data, o0_last, o0_valid,
    input  o0_ready,
    output o1_data, o1_last, o1_valid,
    input  o1_ready
  );
endinterface

// File: rtl/stream_demux.sv
// Packet-locked 1-to-2 stream demultiplexer with a one-entry register buffer per output.
// Define STREAM_DEMUX_CNT_EN to add 16-bit transferred-beat counters o0_cnt/o1_cnt.
module stream_demux #(
  parameter int WIDTH = 1
) (
  input  logic            clk,
  input  logic            rst,
  stream_demux_if.slave   bus
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [15:0]     o0_cnt,
  output logic [15:0]     o1_cnt
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ROUTE0 = 2'd1;
  localparam logic [1:0] ROUTE1 = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             target;
  logic             in_ready;
  logic             accept;
  logic [1:0]       out_ready;

  logic [WIDTH-1:0] buf_data  [2];
  logic             buf_last  [2];
  logic             buf_valid [2];

  assign out_ready = {bus.o1_ready, bus.o0_ready};

  // The first beat of a packet picks the output; later beats follow it.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    target = bus.in_sel;
    case (state)
      ROUTE0:  target = 1'b0;
      ROUTE1:  target = 1'b1;
      default: target = bus.in_sel;
    endcase
  end

  // Ready looks only at the target buffer, never at in_valid.
  always_comb begin
    in_ready = target ? (!buf_valid[1] || out_ready[1])
                      : (!buf_valid[0] || out_ready[0]);
  end

  assign accept = bus.in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        IDLE:    if (!bus.in_last) state_nxt = bus.in_sel ? ROUTE1 : ROUTE0;
        default: if (bus.in_last)  state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A load wins over a drain on the same edge, keeping one beat per cycle per output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: payload registers are reset too, since outputs must read zero during reset.
      for (int n = 0; n < 2; n++) begin
        buf_data[n]  <= '0;
        buf_last[n]  <= 1'b0;
        buf_valid[n] <= 1'b0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (accept && (target == 1'(n))) begin
          buf_data[n]  <= bus.in_data;
          buf_last[n]  <= bus.in_last;
          buf_valid[n] <= 1'b1;
        end else if (buf_valid[n] && out_ready[n]) begin
          buf_valid[n] <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.o0_data  = buf_data[0];
  assign bus.o0_last  = buf_last[0];
  assign bus.o0_valid = buf_valid[0];
  assign bus.o1_data  = buf_data[1];
  assign bus.o1_last  = buf_last[1];
  assign bus.o1_valid = buf_valid[1];

`ifdef STREAM_DEMUX_CNT_EN
  logic [15:0] cnt [2];

  // Counts beats leaving each output; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 2; n++) cnt[n] <= '0;
    end else begin
      for (int n = 0; n < 2; n++)
        if (buf_valid[n] && out_ready[n]) cnt[n] <= cnt[n] + 16'd1;
    end
  end

  assign o0_cnt = cnt[0];
  assign o1_cnt = cnt[1];
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: vector table plus a per-output scoreboard.
module tb_stream_demux;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_demux_if #(.WIDTH(W)) bus ();

`ifdef STREAM_DEMUX_CNT_EN
  logic [15:0] o0_cnt, o1_cnt;
  stream_demux #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave),
                                 .o0_cnt(o0_cnt), .o1_cnt(o1_cnt));
`else
  stream_demux #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: beats pushed on acceptance, popped when they leave an output.
  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];

  logic m_busy, m_tgt, m_v0, m_v1, tgt, exp_rdy, acc;
  beat_t b;

  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      m_busy = 1'b0;
      m_tgt  = 1'b0;
      m_v0   = 1'b0;
      m_v1   = 1'b0;
    end else begin
      tgt     = m_busy ? m_tgt : bus.in_sel;
      exp_rdy = tgt ? (!m_v1 || bus.o1_ready) : (!m_v0 || bus.o0_ready);
      check("mon_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      check("mon_o0_valid", 32'(bus.o0_valid), 32'(m_v0));
      check("mon_o1_valid", 32'(bus.o1_valid), 32'(m_v1));

      if (bus.o0_valid && bus.o0_ready) begin
        if (q0.size() == 0) check("o0_unexpected_beat", 32'(bus.o0_data), 32'hFFFF_FFFF);
        else begin
          b = q0.pop_front();
          check("o0_data", 32'(bus.o0_data), 32'(b.data));
          check("o0_last", 32'(bus.o0_last), 32'(b.last));
        end
      end
      if (bus.o1_valid && bus.o1_ready) begin
        if (q1.size() == 0) check("o1_unexpected_beat", 32'(bus.o1_data), 32'hFFFF_FFFF);
        else begin
          b = q1.pop_front();
          check("o1_data", 32'(bus.o1_data), 32'(b.data));
          check("o1_last", 32'(bus.o1_last), 32'(b.last));
        end
      end

      acc = bus.in_valid && exp_rdy;
      if (acc && !tgt)              m_v0 = 1'b1;
      else if (m_v0 && bus.o0_ready) m_v0 = 1'b0;
      if (acc && tgt)               m_v1 = 1'b1;
      else if (m_v1 && bus.o1_ready) m_v1 = 1'b0;

      if (acc) begin
        b.data = bus.in_data;
        b.last = bus.in_last;
        if (tgt) q1.push_back(b);
        else     q0.push_back(b);
        if (m_busy) begin
          if (bus.in_last) m_busy = 1'b0;
        end else if (!bus.in_last) begin
          m_busy = 1'b1;
          m_tgt  = tgt;
        end
      end
    end
  end

  typedef struct {
    logic [W-1:0] data;
    logic sel, last, valid, r0, r1;
    logic exp_rdy, exp_v0, exp_v1;
  } vec_t;

  vec_t vecs[14];

  task automatic drive(input logic [W-1:0] d, input logic s, input logic l,
                       input logic v, input logic r0, input logic r1);
    bus.in_data  = d;
    bus.in_sel   = s;
    bus.in_last  = l;
    bus.in_valid = v;
    bus.o0_ready = r0;
    bus.o1_ready = r1;
  endtask

  initial begin
    // data sel last valid r0 r1 | in_ready, o0_valid/o1_valid after the edge
    vecs[0]  = '{4'd6,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};  // single beat to o1
    vecs[1]  = '{4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'd5,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};  // packet locked to o0
    vecs[3]  = '{4'd6,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{4'd7,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{4'd9,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};  // o0 backpressure
    vecs[7]  = '{4'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{4'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{4'd10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{4'd11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};  // o0 stalled, o1 streams
    vecs[11] = '{4'd12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[12] = '{4'd13, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    drive('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_o0_valid", 32'(bus.o0_valid), 32'd0);
    check("rst_o1_valid", 32'(bus.o1_valid), 32'd0);
    check("rst_o0_data",  32'(bus.o0_data),  32'd0);
    check("rst_o1_last",  32'(bus.o1_last),  32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].data, vecs[i].sel, vecs[i].last, vecs[i].valid, vecs[i].r0, vecs[i].r1);
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_rdy));
      if (i == 8) check("held_o0_data", 32'(bus.o0_data), 32'd9);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_o0_valid", i), 32'(bus.o0_valid), 32'(vecs[i].exp_v0));
      check($sformatf("vec%0d_o1_valid", i), 32'(bus.o1_valid), 32'(vecs[i].exp_v1));
    end

    // Reset in the middle of a packet routed to o1.
    drive(4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("mid_o1_valid", 32'(bus.o1_valid), 32'd1);
    drive('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("async_o1_valid", 32'(bus.o1_valid), 32'd0);
    check("async_o1_data",  32'(bus.o1_data),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(4'd14, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("post_rst_o0_valid", 32'(bus.o0_valid), 32'd1);
    check("post_rst_o1_valid", 32'(bus.o1_valid), 32'd0);
    drive('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("post_rst_drained", 32'(bus.o0_valid), 32'd0);

`ifdef STREAM_DEMUX_CNT_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("cnt_rst", 32'(o0_cnt), 32'd0);
    drive(4'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    drive('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("cnt_o1_one", 32'(o1_cnt), 32'd1);
    for (int i = 0; i < 65536; i++) begin
      drive(4'(i), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      @(posedge clk);
      #1;
    end
    check("cnt_o0_max", 32'(o0_cnt), 32'h0000_FFFF);
    drive('0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check("cnt_o0_wrap", 32'(o0_cnt), 32'd0);
    check("cnt_o1_kept", 32'(o1_cnt), 32'd1);
`endif

    @(posedge clk);
    #1;
    check("q0_empty", 32'(q0.size()), 32'd0);
    check("q1_empty", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
